ctrl_decode_stage: RTL
======================

# ctrl_decode_stage

Registered, parametrised successor to the combinational RV32I control decoder. It decodes each fetched instruction into an `rv32i_ctrl_word` and queues it in a DEPTH-entry decoded-instruction FIFO with ready/valid handshakes on both sides. It also detects illegal encodings and, optionally, decodes RV32M while holding issue for the multiply/divide unit's busy window. It sits between IF and the ID/EX pipeline register.

## Interface
Parameters:
- `DEPTH`, 2: FIFO entries; power of two, ≥1.
- `MUL_LAT`, 3: issue-blocking cycles for MUL/MULH/MULHSU/MULHU; ≥1.
- `DIV_LAT`, 33: issue-blocking cycles for DIV/DIVU/REM/REMU; ≥1.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `flush` in 1: discard all queued entries and any input this cycle.
- `in_valid` in 1: fetch offers an instruction.
- `in_ready` out 1: stage accepts an instruction; high iff not full and not `rst`.
- `in_instr` in 32: raw instruction.
- `in_pc` in 32: instruction PC.
- `out_valid` out 1: head entry is issuable.
- `out_ready` in 1: downstream accepts the head entry.
- `out_ctrl` out `rv32i_ctrl_word`: decoded control for the head entry.
- `out_pc` out 32: PC of the head entry.
- `out_instr` out 32: raw instruction of the head entry.
- `out_illegal` out 1: head entry is an illegal encoding.
- `out_md_op` out 1: head entry is an RV32M op.
- `out_md_funct3` out 3: RV32M operation select.

## Operation
- Decode is combinational on `in_instr`. The decoded word plus PC, instruction, illegal flag and md fields are written at the tail on push (`in_valid && in_ready && !flush`).
- Defaults: no memory access, `load_regfile=0`, `i_imm`, `rs1_out`/`imm` operands, `alu_add`, `beq`, `pc_plus4`, no jump or branch. `opcode` and `funct3` are copied from the instruction.
- LUI, AUIPC, JAL, JALR, BR, LOAD, STORE and OP-IMM decode identically to the existing decoder.
- OP (register-register):
  - funct3=000 with funct7[5]=1 selects `alu_sub`.
  - funct3=101 selects `alu_sra` when funct7[5]=1, `alu_srl` otherwise.
  - SLT/SLTU use `cmpmux::rs2_out` and `regfilemux::br_en`.
- Illegal conditions:
  - opcode outside the RV32I set;
  - LOAD funct3 ∈ {011, 110, 111};
  - STORE funct3 > 010;
  - BR funct3 ∈ {010, 011};
  - OP funct7 ∉ {0000000, 0100000}, or funct7=0100000 with funct3 ∉ {000, 101};
  - OP-IMM funct3=001 with funct7≠0, or funct3=101 with funct7 ∉ {0000000, 0100000}.
- An illegal entry stores defaults with `load_regfile=0`, `mem_read=0`, `mem_write=0` and `out_illegal=1`.
- CSR/SYSTEM decodes to defaults and is not illegal.
- Pop on `out_valid && out_ready`.
- `out_valid = (count≠0) && (md_cnt==0)`.
- When the popped entry has `out_md_op=1`, `md_cnt` loads LAT−1 (MUL_LAT for funct3[2]=0, DIV_LAT for funct3[2]=1). `md_cnt` decrements each cycle while nonzero.
- Output fields always reflect storage at the head pointer, including when the FIFO is empty.

## Timing
- Reset: count, head and tail pointers, `md_cnt` and all storage go to 0. During reset `out_valid=0`, `out_illegal=0`, `out_md_op=0` and `in_ready=0`. `in_ready=1` in the first cycle after reset.
- Latency: an instruction pushed in cycle t is at the head and valid in t+1 when the FIFO was empty and `md_cnt==0`. There is no same-cycle bypass.
- Full: `in_ready=0`. A pop while full does not admit a push in the same cycle (`in_ready` depends on count only).
- Empty and valid push: `out_valid` stays 0 that cycle.
- Simultaneous push and pop when not full: count is unchanged and both pointers advance, wrapping modulo DEPTH.
- `flush`: count, head and tail go to 0 next cycle and any push that cycle is dropped. `md_cnt` is not cleared because the unit is still busy. A pop concurrent with flush still completes and still loads `md_cnt`.
- With an M op issued at cycle t, the next issue is no earlier than t+LAT. LAT=1 adds no stall.
- `out_ready` has no combinational path to `in_ready`.

## Configuration
- `RV32M_EN` defined:
  - OP with funct7=0000001 is legal;
  - `out_md_op=1`, `out_md_funct3=funct3`, `regfilemux::alu_out`;
  - `md_cnt` and its issue gating exist.
- Undefined:
  - funct7=0000001 is illegal;
  - `out_md_op` and `out_md_funct3` are tied to 0;
  - no `md_cnt` and no gating; MUL_LAT and DIV_LAT are ignored.

## Test plan
- Reset, then push ADD x3,x1,x2 (0x002081B3) with `out_ready=1` → `out_valid` rises next cycle, `alumux2_sel=rs2_out`, `aluop=alu_add`, `load_regfile=1`, `out_illegal=0`.
- DEPTH=2, `out_ready=0`, push 3 instructions → `in_ready=0` after 2 pushes. Raise `out_ready` → entries pop in order with matching `out_pc`.
- Push SUB (0x402081B3), then 0xFFFFFFFF, then LOAD with funct3=011 → first decodes `alu_sub`; the other two give `out_illegal=1`, `load_regfile=0`, `mem_read=0`.
- `RV32M_EN`, DIV_LAT=33: push DIV (0x0220C1B3) then ADD, with `out_ready=1` → ADD issues exactly 33 cycles after DIV. Repeat without `RV32M_EN` → DIV is illegal and ADD issues on the next cycle.
- Fill 2 entries and assert `flush` with `in_valid=1` → `out_valid=0` next cycle, `in_ready=1`, and the flushed-cycle instruction never appears.
- Pointer wrap: 10 back-to-back push/pop cycles with `out_ready=1` → 10 in-order outputs, count stays ≤1.

Source files
------------

// File: rtl/ctrl_decode_stage.sv
// RV32I decode stage: decodes fetched instructions into rv32i_ctrl_word and queues them in a DEPTH-entry FIFO.
// Define RV32M_EN to decode RV32M and hold issue while the multiply/divide unit is busy.

package ctrl_decode_stage_pkg;
  localparam logic [6:0] op_lui   = 7'b0110111;
  localparam logic [6:0] op_auipc = 7'b0010111;
  localparam logic [6:0] op_jal   = 7'b1101111;
  localparam logic [6:0] op_jalr  = 7'b1100111;
  localparam logic [6:0] op_br    = 7'b1100011;
  localparam logic [6:0] op_load  = 7'b0000011;
  localparam logic [6:0] op_store = 7'b0100011;
  localparam logic [6:0] op_imm   = 7'b0010011;
  localparam logic [6:0] op_reg   = 7'b0110011;
  localparam logic [6:0] op_csr   = 7'b1110011;

  localparam logic [2:0] alu_add = 3'b000;
  localparam logic [2:0] alu_sll = 3'b001;
  localparam logic [2:0] alu_sra = 3'b010;
  localparam logic [2:0] alu_sub = 3'b011;
  localparam logic [2:0] alu_srl = 3'b101;

  localparam logic [2:0] cmp_beq  = 3'b000;
  localparam logic [2:0] cmp_blt  = 3'b100;
  localparam logic [2:0] cmp_bltu = 3'b110;

  localparam logic alumux1_rs1_out = 1'b0;
  localparam logic alumux1_pc_out  = 1'b1;

  localparam logic [2:0] alumux2_i_imm   = 3'd0;
  localparam logic [2:0] alumux2_u_imm   = 3'd1;
  localparam logic [2:0] alumux2_b_imm   = 3'd2;
  localparam logic [2:0] alumux2_s_imm   = 3'd3;
  localparam logic [2:0] alumux2_j_imm   = 3'd4;
  localparam logic [2:0] alumux2_rs2_out = 3'd5;

  localparam logic cmpmux_rs2_out = 1'b0;
  localparam logic cmpmux_i_imm   = 1'b1;

  localparam logic [3:0] regfilemux_alu_out  = 4'd0;
  localparam logic [3:0] regfilemux_br_en    = 4'd1;
  localparam logic [3:0] regfilemux_u_imm    = 4'd2;
  localparam logic [3:0] regfilemux_lw       = 4'd3;
  localparam logic [3:0] regfilemux_pc_plus4 = 4'd4;
  localparam logic [3:0] regfilemux_lb       = 4'd5;
  localparam logic [3:0] regfilemux_lbu      = 4'd6;
  localparam logic [3:0] regfilemux_lh       = 4'd7;
  localparam logic [3:0] regfilemux_lhu      = 4'd8;

  localparam logic [1:0] pcmux_pc_plus4 = 2'd0;
  localparam logic [1:0] pcmux_alu_out  = 2'd1;
  localparam logic [1:0] pcmux_alu_mod2 = 2'd2;

  typedef struct packed {
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [2:0] aluop;
    logic [2:0] cmpop;
    logic       alumux1_sel;
    logic [2:0] alumux2_sel;
    logic       cmpmux_sel;
    logic [3:0] regfilemux_sel;
    logic [1:0] pcmux_sel;
    logic       load_regfile;
    logic       mem_read;
    logic       mem_write;
    logic       jump;
    logic       branch;
  } rv32i_ctrl_word;

  typedef struct packed {
    rv32i_ctrl_word ctrl;
    logic [31:0]    pc;
    logic [31:0]    instr;
    logic           illegal;
`ifdef RV32M_EN
    logic           md_op;
    logic [2:0]     md_funct3;
`endif
  } dec_entry_t;
endpackage

module ctrl_decode_stage
  import ctrl_decode_stage_pkg::*;
#(
  parameter int unsigned DEPTH   = 2,
  parameter int unsigned MUL_LAT = 3,
  parameter int unsigned DIV_LAT = 33
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           flush,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [31:0]    in_instr,
  input  logic [31:0]    in_pc,
  output logic           out_valid,
  input  logic           out_ready,
  output rv32i_ctrl_word out_ctrl,
  output logic [31:0]    out_pc,
  output logic [31:0]    out_instr,
  output logic           out_illegal,
  output logic           out_md_op,
  output logic [2:0]     out_md_funct3
);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  if (DEPTH < 1 || (DEPTH & (DEPTH - 1)) != 0 || MUL_LAT < 1 || DIV_LAT < 1) begin : g_param_check
    $error("ctrl_decode_stage: DEPTH must be a power of two and latencies at least 1");
  end

  logic [6:0]     funct7;
  rv32i_ctrl_word base;
  rv32i_ctrl_word ctrl;
  logic           illegal;
`ifdef RV32M_EN
  logic           md_op;
`endif

  assign funct7 = in_instr[31:25];

  // Neutral control word every decode starts from; illegal entries keep exactly this.
  always_comb begin
    base                = '0;
    base.opcode         = in_instr[6:0];
    base.funct3         = in_instr[14:12];
    base.aluop          = alu_add;
    base.cmpop          = cmp_beq;
    base.alumux1_sel    = alumux1_rs1_out;
    base.alumux2_sel    = alumux2_i_imm;
    base.cmpmux_sel     = cmpmux_i_imm;
    base.regfilemux_sel = regfilemux_alu_out;
    base.pcmux_sel      = pcmux_pc_plus4;
  end

  always_comb begin
    ctrl    = base;
    illegal = 1'b0;
`ifdef RV32M_EN
    md_op   = 1'b0;
`endif
    case (base.opcode)
      op_lui: begin
        ctrl.load_regfile   = 1'b1;
        ctrl.regfilemux_sel = regfilemux_u_imm;
      end
      op_auipc: begin
        ctrl.load_regfile = 1'b1;
        ctrl.alumux1_sel  = alumux1_pc_out;
        ctrl.alumux2_sel  = alumux2_u_imm;
      end
      op_jal: begin
        ctrl.load_regfile   = 1'b1;
        ctrl.alumux1_sel    = alumux1_pc_out;
        ctrl.alumux2_sel    = alumux2_j_imm;
        ctrl.regfilemux_sel = regfilemux_pc_plus4;
        ctrl.pcmux_sel      = pcmux_alu_out;
        ctrl.jump           = 1'b1;
      end
      op_jalr: begin
        ctrl.load_regfile   = 1'b1;
        ctrl.regfilemux_sel = regfilemux_pc_plus4;
        ctrl.pcmux_sel      = pcmux_alu_mod2;
        ctrl.jump           = 1'b1;
      end
      op_br: begin
        ctrl.alumux1_sel = alumux1_pc_out;
        ctrl.alumux2_sel = alumux2_b_imm;
        ctrl.cmpmux_sel  = cmpmux_rs2_out;
        ctrl.cmpop       = base.funct3;
        ctrl.branch      = 1'b1;
        illegal          = (base.funct3 == 3'b010) || (base.funct3 == 3'b011);
      end
      op_load: begin
        ctrl.load_regfile = 1'b1;
        ctrl.mem_read     = 1'b1;
        case (base.funct3)
          3'b000:  ctrl.regfilemux_sel = regfilemux_lb;
          3'b001:  ctrl.regfilemux_sel = regfilemux_lh;
          3'b010:  ctrl.regfilemux_sel = regfilemux_lw;
          3'b100:  ctrl.regfilemux_sel = regfilemux_lbu;
          3'b101:  ctrl.regfilemux_sel = regfilemux_lhu;
          default: illegal = 1'b1;
        endcase
      end
      op_store: begin
        ctrl.mem_write   = 1'b1;
        ctrl.alumux2_sel = alumux2_s_imm;
        illegal          = (base.funct3 > 3'b010);
      end
      op_imm: begin
        ctrl.load_regfile = 1'b1;
        case (base.funct3)
          3'b010: begin
            ctrl.cmpop          = cmp_blt;
            ctrl.regfilemux_sel = regfilemux_br_en;
          end
          3'b011: begin
            ctrl.cmpop          = cmp_bltu;
            ctrl.regfilemux_sel = regfilemux_br_en;
          end
          3'b001: begin
            ctrl.aluop = alu_sll;
            illegal    = (funct7 != 7'b0000000);
          end
          3'b101: begin
            ctrl.aluop = funct7[5] ? alu_sra : alu_srl;
            illegal    = (funct7 != 7'b0000000) && (funct7 != 7'b0100000);
          end
          default: ctrl.aluop = base.funct3;
        endcase
      end
      op_reg: begin
        ctrl.load_regfile = 1'b1;
        ctrl.alumux2_sel  = alumux2_rs2_out;
`ifdef RV32M_EN
        if (funct7 == 7'b0000001) begin
          md_op = 1'b1;
        end else
`endif
        if (funct7 == 7'b0100000) begin
          case (base.funct3)
            3'b000:  ctrl.aluop = alu_sub;
            3'b101:  ctrl.aluop = alu_sra;
            default: illegal = 1'b1;
          endcase
        end else if (funct7 == 7'b0000000) begin
          case (base.funct3)
            3'b010: begin
              ctrl.cmpop          = cmp_blt;
              ctrl.cmpmux_sel     = cmpmux_rs2_out;
              ctrl.regfilemux_sel = regfilemux_br_en;
            end
            3'b011: begin
              ctrl.cmpop          = cmp_bltu;
              ctrl.cmpmux_sel     = cmpmux_rs2_out;
              ctrl.regfilemux_sel = regfilemux_br_en;
            end
            3'b101:  ctrl.aluop = alu_srl;
            default: ctrl.aluop = base.funct3;
          endcase
        end else begin
          illegal = 1'b1;
        end
      end
      op_csr: ;
      default: illegal = 1'b1;
    endcase
    if (illegal) begin
      ctrl = base;
    end
  end

  dec_entry_t             wr_entry;
  dec_entry_t             head_entry;
  dec_entry_t             mem [DEPTH];
  logic [PTR_W-1:0]       head;
  logic [PTR_W-1:0]       tail;
  logic [PTR_W-1:0]       head_nxt;
  logic [PTR_W-1:0]       tail_nxt;
  logic [CNT_W-1:0]       count;
  logic                   md_idle;
  logic                   push;
  logic                   pop;

  always_comb begin
    wr_entry.ctrl      = ctrl;
    wr_entry.pc        = in_pc;
    wr_entry.instr     = in_instr;
    wr_entry.illegal   = illegal;
`ifdef RV32M_EN
    wr_entry.md_op     = md_op;
    wr_entry.md_funct3 = md_op ? base.funct3 : 3'b000;
`endif
  end

  assign head_entry = mem[head];
  assign head_nxt   = (head == PTR_W'(DEPTH - 1)) ? '0 : head + PTR_W'(1);
  assign tail_nxt   = (tail == PTR_W'(DEPTH - 1)) ? '0 : tail + PTR_W'(1);

  // Readiness depends only on occupancy, so out_ready never reaches in_ready.
  assign in_ready  = !rst && (count != CNT_W'(DEPTH));
  assign out_valid = !rst && (count != '0) && md_idle;
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready;

  assign out_ctrl    = head_entry.ctrl;
  assign out_pc      = head_entry.pc;
  assign out_instr   = head_entry.instr;
  assign out_illegal = !rst && head_entry.illegal;

  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      mem   <= '{default: '0};
    end else begin
      if (push) begin
        mem[tail] <= wr_entry;
      end
      if (flush) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (push) tail <= tail_nxt;
        if (pop)  head <= head_nxt;
        if (push && !pop) begin
          count <= count + CNT_W'(1);
        end else if (!push && pop) begin
          count <= count - CNT_W'(1);
        end
      end
    end
  end

`ifdef RV32M_EN
  localparam int unsigned MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int unsigned MD_W    = $clog2(MAX_LAT + 1);

  logic [MD_W-1:0] md_cnt;

  // Busy window of the mul/div unit; survives flush because the unit keeps running.
  always_ff @(posedge clk) begin
    if (rst) begin
      md_cnt <= '0;
    end else if (pop && head_entry.md_op) begin
      md_cnt <= head_entry.md_funct3[2] ? MD_W'(DIV_LAT - 1) : MD_W'(MUL_LAT - 1);
    end else if (md_cnt != '0) begin
      md_cnt <= md_cnt - MD_W'(1);
    end
  end

  assign md_idle       = (md_cnt == '0);
  assign out_md_op     = !rst && head_entry.md_op;
  assign out_md_funct3 = head_entry.md_funct3;
`else
  assign md_idle       = 1'b1;
  assign out_md_op     = 1'b0;
  assign out_md_funct3 = 3'b000;
`endif

endmodule
